irq_ctrl: RTL

//  Interrupt controller sequencing the RV32i datapath's ISRsel/ISR/suspend inputs.

---
 rtl/irq_ctrl_if.sv | 42 ++++
 rtl/irq_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl_if
// Brief    : Bundles the request lines and datapath sequencing signals
//            of the interrupt controller. master = controller side,
//            slave = datapath / request source side.
// Revision : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if #(
  parameter int NIRQ = 8
);
  localparam int ID_W = $clog2(NIRQ);

  // request side
  logic [NIRQ-1:0] irq;
  logic [NIRQ-1:0] irq_en;
  logic            gie;
  // datapath side
  logic            stall;
  logic            mret;
  logic [31:0]     epc;
  logic            ISRsel;
  logic [31:0]     ISR;
  logic            suspend;
  logic            squash;
  // status
  logic [NIRQ-1:0] irq_ack;
  logic [ID_W-1:0] active_id;
  logic            in_service;
  logic [NIRQ-1:0] pending;

  modport master (
    input  irq, irq_en, gie, stall, mret, epc,
    output ISRsel, ISR, suspend, squash, irq_ack, active_id, in_service, pending
  );

  modport slave (
    output irq, irq_en, gie, stall, mret, epc,
    input  ISRsel, ISR, suspend, squash, irq_ack, active_id, in_service, pending
  );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_ctrl
// Brief    : Vectored interrupt controller for the RV32i datapath. Latches
//            rising edges on the request lines, takes the lowest-index
//            enabled request at an instruction boundary, redirects the PC to
//            its vector and squashes the interrupted instruction; mret
//            returns to the saved EPC. No nesting.
// Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl #(
  parameter int          NIRQ       = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 4,
  parameter int          ID_W       = $clog2(NIRQ)
) (
  input  logic          clk,
  input  logic          reset,
  irq_ctrl_if.master    bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTER   = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] S_RECOVER = 2'd3;

  logic [1:0]      r_state;
  logic [1:0]      w_state_nxt;
  logic [NIRQ-1:0] r_irq_q;
  logic [NIRQ-1:0] r_pending;
  logic [NIRQ-1:0] w_pending_nxt;
  logic [NIRQ-1:0] w_rise;
  logic [NIRQ-1:0] w_eligible;
  logic [NIRQ-1:0] w_active_onehot;
  logic [NIRQ-1:0] w_clear;
  logic [ID_W-1:0] r_active_id;
  logic [ID_W-1:0] w_winner;
  logic            w_take;
  logic            w_return;
  logic [31:0]     w_vector;

  assign w_rise          = bus.irq & ~r_irq_q;
  assign w_eligible      = r_pending & bus.irq_en;
  assign w_active_onehot = {{(NIRQ-1){1'b0}}, 1'b1} << r_active_id;
  // The serviced line is only retired while ENTER is active; a fresh edge
  // on the same line in that cycle must survive, so set is OR-ed in last.
  assign w_clear         = (r_state == S_ENTER) ? w_active_onehot : '0;
  assign w_pending_nxt   = (r_pending & ~w_clear) | w_rise;

  assign w_take   = (r_state == S_IDLE) && bus.gie && (|w_eligible) && !bus.stall;
  assign w_return = (r_state == S_SERVICE) && bus.mret && !bus.stall;
  assign w_vector = VEC_BASE + (32'(r_active_id) * VEC_STRIDE);

  // Lowest-index eligible line wins: scan downwards so the last hit is lowest.
  always_comb begin
    w_winner = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_eligible[i]) w_winner = ID_W'(i);
    end
  end

  // Next-state logic; ENTER and RECOVER are single-cycle bubbles.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_take) w_state_nxt = S_ENTER;
      S_ENTER:   w_state_nxt = S_SERVICE;
      S_SERVICE: if (w_return) w_state_nxt = S_RECOVER;
      S_RECOVER: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // State, edge history, pending latch and captured line id.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_irq_q     <= '0;
      r_pending   <= '0;
      r_active_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_irq_q   <= bus.irq;
      r_pending <= w_pending_nxt;
      if (w_take) r_active_id <= w_winner;
    end
  end

  // Datapath controls are decoded from state; ISR is forced to zero
  // whenever no redirect is requested.
  always_comb begin
    bus.ISRsel  = 1'b0;
    bus.ISR     = 32'h0;
    bus.suspend = 1'b0;
    bus.squash  = 1'b0;
    bus.irq_ack = '0;
    if (r_state == S_ENTER) begin
      bus.ISRsel  = 1'b1;
      bus.ISR     = w_vector;
      bus.suspend = 1'b1;
      bus.squash  = 1'b1;
      bus.irq_ack = w_active_onehot;
    end else if (w_return) begin
      bus.ISRsel  = 1'b1;
      bus.ISR     = bus.epc;
    end
  end

  assign bus.active_id  = r_active_id;
  assign bus.in_service = (r_state == S_SERVICE);
  assign bus.pending    = r_pending;

endmodule
`default_nettype wire
